parity_sched: RTL and testbench
===============================

# parity_sched

Two-requester scheduler that shares one serial parity engine. Each requester offers a WIDTH-bit word over a valid/ready handshake, and a round-robin arbiter picks one word at a time. The engine shifts the accepted word LSB-first through a two-state even/odd tracker, one bit per clock, then presents the parity result with the winning requester's id on a valid/ready result port. The block sits between the word producers and any downstream consumer of parity bits.

## Interface
- WIDTH, default 8: data word width in bits; legal range is 2 or more.
- ODD_MODE, default 0: parity sense.
  - 0: res_parity is the XOR of all bits, i.e. 1 when the word has an odd number of ones.
  - 1: res_parity is the inverse of that value, i.e. the odd-parity bit.

- clk  input  1  clock; everything is rising-edge triggered.
- rst  input  1  synchronous, active-high reset.
- req0_valid  input  1  requester 0 has a word.
- req0_data  input  WIDTH  requester 0 word.
- req0_ready  output  1  requester 0 word is accepted this cycle.
- req1_valid  input  1  requester 1 has a word.
- req1_data  input  WIDTH  requester 1 word.
- req1_ready  output  1  requester 1 word is accepted this cycle.
- res_valid  output  1  a result is available.
- res_id  output  1  requester that the result belongs to.
- res_parity  output  1  parity result.
- res_ready  input  1  consumer takes the result.
- busy  output  1  high whenever the state is not IDLE.

## Operation
- FSM states:
  - IDLE: waits for a request and arbitrates.
  - SHIFT: serial parity computation.
  - DONE: holds the result until it is taken.
- Reset (rst high at a clock edge) sets:
  - state to IDLE, last_grant to 1 (so requester 0 wins the first tie);
  - res_valid, res_id, res_parity and busy to 0;
  - the shift register, bit counter and parity tracker to 0.
- While rst is high, req0_ready and req1_ready are forced to 0.
- Arbitration in IDLE is combinational from the valid inputs:
  - only req0_valid high: grant 0;
  - only req1_valid high: grant 1;
  - both high: grant the requester that is not last_grant.
- Ready rules:
  - reqN_ready = (state==IDLE) & reqN_valid & (grant==N).
  - At most one ready is high in any cycle.
  - Ready is never high outside IDLE.
- Handshake in IDLE (reqN_valid & reqN_ready at an edge):
  - load the shift register with reqN_data;
  - set the bit counter to WIDTH and the tracker to even;
  - set last_grant and res_id to N;
  - go to SHIFT.
- SHIFT, at each edge:
  - tracker becomes tracker XOR sr[0];
  - the shift register shifts right by 1;
  - the counter decrements.
  - When the counter reaches 1 at an edge, that edge consumes the last bit and goes to DONE.
  - The tracker behaves like a two-state machine: even stays even on 0 and flips to odd on 1; odd flips back to even on 1.
- DONE:
  - res_valid is 1 and res_parity is the tracker value XOR ODD_MODE.
  - res_id and res_parity are stable while res_valid is high.
  - On res_valid & res_ready, go to IDLE and clear res_valid at that edge.
- Requester data is sampled only at its handshake edge. Later changes to reqN_data do not affect the result in flight.
- The counter is $clog2(WIDTH+1) bits wide and never wraps: it is loaded only in IDLE and stops at DONE.

## Timing
- Handshake in cycle c gives:
  - SHIFT in cycles c+1 through c+WIDTH;
  - res_valid high from cycle c+WIDTH+1.
- Result latency from acceptance is WIDTH+1 cycles.
- With res_ready tied high:
  - res_valid is high for 1 cycle;
  - IDLE is in cycle c+WIDTH+2;
  - the next acceptance happens no earlier than cycle c+WIDTH+2.
  - Peak throughput is one word per WIDTH+2 cycles.
- Backpressure: res_valid stays high for as long as res_ready is low. No new request is accepted, and both readies stay 0.
- A request arriving while busy waits; its valid must stay high until ready.
- Reset in the middle of SHIFT or DONE abandons the word. No result is emitted, and the next cycle is IDLE with all outputs at their reset values.
- A requester that drops valid before being granted is simply not served. There is no latching of requests.
- busy rises the cycle after acceptance and falls the cycle after the result handshake.

## Test plan
- Single word, WIDTH=8, ODD_MODE=0:
  - req0 sends 8'hA5 -> res_valid in cycle c+9 with res_id=0, res_parity=0.
  - req0 sends 8'h07 -> res_parity=1.
- Tie after reset:
  - req0=8'h01 and req1=8'h03 both valid with res_ready=1 -> first result id=0/parity=1, then id=1/parity=0.
  - Second acceptance occurs exactly 10 cycles after the first.
- Back-to-back fairness: both requesters valid for 4 words -> grants alternate 0,1,0,1 with no starvation.
- Backpressure: hold res_ready=0 for 5 cycles in DONE -> res_valid, res_id and res_parity are held; both readies stay 0; busy=1.
- Reset mid-SHIFT: assert rst in cycle c+3 -> no res_valid ever appears for that word; busy=0 and IDLE follow. A new req1 word of 8'hFF then gives parity 0.
- ODD_MODE=1: req1 sends 8'h00 -> res_parity=1; req1 sends 8'h80 -> res_parity=0.

Source files
------------

// File: rtl/parity_sched.sv
// Two-requester round-robin front end sharing one bit-serial parity engine.
// Words are shifted LSB-first through an even/odd tracker; the result is held until taken.
module parity_sched #(
    parameter int WIDTH    = 8,
    parameter int ODD_MODE = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req0_valid,
    input  logic [WIDTH-1:0] req0_data,
    output logic             req0_ready,
    input  logic             req1_valid,
    input  logic [WIDTH-1:0] req1_data,
    output logic             req1_ready,
    output logic             res_valid,
    output logic             res_id,
    output logic             res_parity,
    input  logic             res_ready,
    output logic             busy
);

    localparam int   CW      = $clog2(WIDTH + 1);
    localparam logic ODD_BIT = (ODD_MODE != 0);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t           state_q;
    logic             last_grant_q;
    logic [WIDTH-1:0] sr_q;
    logic [CW-1:0]    cnt_q;
    logic             trk_q;
    logic             res_valid_q;
    logic             res_id_q;
    logic             res_parity_q;
    logic             busy_q;

    logic             grant_d;
    logic             accept_d;
    logic             trk_d;

    // Two-state even/odd tracker: a 1 bit toggles, a 0 bit holds.
    function automatic logic trk_step(input logic trk, input logic bit_in);
        return trk ^ bit_in;
    endfunction

    // Round-robin pick: on a tie the requester that did not win last time is served.
    always_comb begin
        grant_d = 1'b0;
        if (req0_valid && req1_valid) begin
            grant_d = ~last_grant_q;
        end else if (req1_valid) begin
            grant_d = 1'b1;
        end else begin
            grant_d = 1'b0;
        end
    end

    assign req0_ready = ~rst & (state_q == IDLE) & req0_valid & ~grant_d;
    assign req1_ready = ~rst & (state_q == IDLE) & req1_valid &  grant_d;
    assign accept_d   = req0_ready | req1_ready;
    assign trk_d      = trk_step(trk_q, sr_q[0]);

    // Scheduler FSM, serial engine and registered result port.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            last_grant_q <= 1'b1;
            sr_q         <= '0;
            cnt_q        <= '0;
            trk_q        <= 1'b0;
            res_valid_q  <= 1'b0;
            res_id_q     <= 1'b0;
            res_parity_q <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (accept_d) begin
                        sr_q         <= grant_d ? req1_data : req0_data;
                        cnt_q        <= CW'(WIDTH);
                        trk_q        <= 1'b0;
                        last_grant_q <= grant_d;
                        res_id_q     <= grant_d;
                        busy_q       <= 1'b1;
                        state_q      <= SHIFT;
                    end
                end
                SHIFT: begin
                    trk_q <= trk_d;
                    sr_q  <= sr_q >> 1;
                    cnt_q <= cnt_q - CW'(1);
                    // The edge that sees count 1 consumes the final bit.
                    if (cnt_q == CW'(1)) begin
                        res_valid_q  <= 1'b1;
                        res_parity_q <= trk_d ^ ODD_BIT;
                        state_q      <= DONE;
                    end
                end
                DONE: begin
                    if (res_ready) begin
                        res_valid_q <= 1'b0;
                        busy_q      <= 1'b0;
                        state_q     <= IDLE;
                    end
                end
                default: begin
                    res_valid_q <= 1'b0;
                    busy_q      <= 1'b0;
                    state_q     <= IDLE;
                end
            endcase
        end
    end

    assign res_valid  = res_valid_q;
    assign res_id     = res_id_q;
    assign res_parity = res_parity_q;
    assign busy       = busy_q;

endmodule

// File: tb/tb_parity_sched.sv
// Directed bench for parity_sched: one even-mode and one odd-mode instance
// sharing clock, reset and res_ready.
module tb_parity_sched;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst, res_ready;
    logic a_v0, a_v1, a_r0, a_r1, a_rv, a_id, a_par, a_busy;
    logic b_v0, b_v1, b_r0, b_r1, b_rv, b_id, b_par, b_busy;
    logic [7:0] a_d0, a_d1, b_d0, b_d1;

    parity_sched #(.WIDTH(8), .ODD_MODE(0)) u_even (
        .clk(clk), .rst(rst),
        .req0_valid(a_v0), .req0_data(a_d0), .req0_ready(a_r0),
        .req1_valid(a_v1), .req1_data(a_d1), .req1_ready(a_r1),
        .res_valid(a_rv), .res_id(a_id), .res_parity(a_par),
        .res_ready(res_ready), .busy(a_busy)
    );

    parity_sched #(.WIDTH(8), .ODD_MODE(1)) u_odd (
        .clk(clk), .rst(rst),
        .req0_valid(b_v0), .req0_data(b_d0), .req0_ready(b_r0),
        .req1_valid(b_v1), .req1_data(b_d1), .req1_ready(b_r1),
        .res_valid(b_rv), .res_id(b_id), .res_parity(b_par),
        .res_ready(res_ready), .busy(b_busy)
    );

    int n_checks = 0;
    int n_errs   = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errs++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic cur_ready(input bit sel, input bit id);
        return sel ? (id ? b_r1 : b_r0) : (id ? a_r1 : a_r0);
    endfunction

    function automatic logic cur_rv(input bit sel);
        return sel ? b_rv : a_rv;
    endfunction

    task automatic drive(input bit sel, input bit id, input logic v, input logic [7:0] d);
        if (!sel) begin
            if (id) begin a_v1 = v; a_d1 = d; end else begin a_v0 = v; a_d0 = d; end
        end else begin
            if (id) begin b_v1 = v; b_d1 = d; end else begin b_v0 = v; b_d0 = d; end
        end
    endtask

    // One word end to end: accept, check latency, id and parity, then take the result.
    task automatic xfer(input bit sel, input bit id, input logic [7:0] d,
                        input logic exp_par, input string tag);
        int w;
        int lat;
        drive(sel, id, 1'b1, d);
        #1;
        w = 0;
        while (!cur_ready(sel, id) && w < 20) begin tick(); w++; end
        check({tag, "_ready"}, cur_ready(sel, id), 1);
        tick();
        drive(sel, id, 1'b0, d ^ 8'h01);
        check({tag, "_busy"}, sel ? b_busy : a_busy, 1);
        lat = 0;
        while (!cur_rv(sel) && lat < 30) begin tick(); lat++; end
        check({tag, "_lat"}, lat, 8);
        check({tag, "_id"}, sel ? b_id : a_id, id);
        check({tag, "_par"}, sel ? b_par : a_par, exp_par);
        res_ready = 1'b1;
        tick();
        res_ready = 1'b0;
        check({tag, "_rvclr"}, cur_rv(sel), 0);
        check({tag, "_idle"}, sel ? b_busy : a_busy, 0);
    endtask

    int g_id[4], g_cyc[4], r_id[4], r_par[4];
    int n_g, n_r, w, seen;

    initial begin
        rst = 1'b1; res_ready = 1'b0;
        a_v0 = 1'b1; a_v1 = 1'b0; a_d0 = 8'h00; a_d1 = 8'h00;
        b_v0 = 1'b0; b_v1 = 1'b0; b_d0 = 8'h00; b_d1 = 8'h00;
        tick(); tick();
        check("rst_ready0", a_r0, 0);
        check("rst_rv", a_rv, 0);
        check("rst_id", a_id, 0);
        check("rst_par", a_par, 0);
        check("rst_busy", a_busy, 0);
        a_v0 = 1'b0;
        rst = 1'b0;
        tick();

        xfer(1'b0, 1'b0, 8'hA5, 1'b0, "a5");
        xfer(1'b0, 1'b0, 8'h07, 1'b1, "07");

        // Backpressure: result must hold and no requester may be accepted.
        a_d1 = 8'h0B; a_v1 = 1'b1;
        #1;
        check("bp_ready1", a_r1, 1);
        tick();
        a_v1 = 1'b0;
        w = 0;
        while (!a_rv && w < 30) begin tick(); w++; end
        check("bp_lat", w, 8);
        a_v0 = 1'b1; a_v1 = 1'b1;
        #1;
        for (int k = 0; k < 5; k++) begin
            check("bp_rv", a_rv, 1);
            check("bp_id", a_id, 1);
            check("bp_par", a_par, 1);
            check("bp_r0", a_r0, 0);
            check("bp_r1", a_r1, 0);
            check("bp_busy", a_busy, 1);
            tick();
        end
        a_v0 = 1'b0; a_v1 = 1'b0;
        res_ready = 1'b1;
        tick();
        res_ready = 1'b0;
        check("bp_rvclr", a_rv, 0);

        // Tie after reset, then continuous contention for four words.
        rst = 1'b1; tick(); rst = 1'b0;
        a_d0 = 8'h01; a_d1 = 8'h03; a_v0 = 1'b1; a_v1 = 1'b1;
        res_ready = 1'b1;
        #1;
        n_g = 0; n_r = 0;
        for (int k = 0; k < 80 && n_r < 4; k++) begin
            if (n_g < 4 && (a_r0 || a_r1)) begin
                g_id[n_g] = a_r1 ? 1 : 0; g_cyc[n_g] = k; n_g++;
            end
            if (a_rv) begin
                r_id[n_r] = a_id; r_par[n_r] = a_par; n_r++;
                if (n_r == 4) begin a_v0 = 1'b0; a_v1 = 1'b0; end
            end
            tick();
        end
        res_ready = 1'b0;
        check("rr_ngrants", n_g, 4);
        check("rr_nres", n_r, 4);
        for (int k = 0; k < 4; k++) begin
            check("rr_grant", (k < n_g) ? g_id[k] : -1, k % 2);
            check("rr_res_id", (k < n_r) ? r_id[k] : -1, k % 2);
            check("rr_res_par", (k < n_r) ? r_par[k] : -1, (k % 2 == 0) ? 1 : 0);
        end
        check("rr_spacing", (n_g > 1) ? (g_cyc[1] - g_cyc[0]) : -1, 10);

        // Reset in the middle of SHIFT abandons the word.
        a_d0 = 8'h01; a_v0 = 1'b1;
        #1;
        check("ms_ready0", a_r0, 1);
        tick();
        a_v0 = 1'b0;
        tick(); tick();
        rst = 1'b1; tick(); rst = 1'b0;
        check("ms_busy", a_busy, 0);
        check("ms_rv", a_rv, 0);
        seen = 0;
        for (int k = 0; k < 15; k++) begin
            if (a_rv) seen++;
            tick();
        end
        check("ms_noresult", seen, 0);
        xfer(1'b0, 1'b1, 8'hFF, 1'b0, "ff");

        xfer(1'b1, 1'b1, 8'h00, 1'b1, "odd00");
        xfer(1'b1, 1'b1, 8'h80, 1'b0, "odd80");

        $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
        $finish;
    end

endmodule
